// File: rtl/mem_wb_pkg.sv
// Shared opcodes, FSM state type and default widths for the MEM/WB stage.
package mem_wb_pkg;

    localparam int DATA_W_DEFAULT = 32;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_wb_stage_timer.sv
// mem_ack_timer: counts cycles spent in MEM; tc flags the last cycle before
// an ack timeout (the LIMIT-th cycle in MEM).
module mem_ack_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !tc) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = enable && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS-32 memory-access / write-back stage with req/ack data memory port.
// Optional MEM_WB_FWD_EN adds a registered copy of the write port.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [5:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [4:0]        ex_dest,
    input  logic              ex_reg_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              write,
    output logic [4:0]        write_address,
    output logic [DATA_W-1:0] write_material,
    output logic              stall,
    output logic              mem_err
`ifdef MEM_WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [4:0]        fwd_addr,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    state_t            state_q, state_d;
    logic [4:0]        dest_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              accept, is_mem_op, enter_mem, load_done, timer_tc, timeout;

    assign ex_ready  = (state_q != ST_MEM);
    assign accept    = ex_valid && ex_ready;
    assign is_mem_op = (ex_opcode == OP_LW) || (ex_opcode == OP_SW);
    assign enter_mem = accept && is_mem_op;
    assign load_done = (state_q == ST_MEM) && dmem_ack && !dmem_we;
    // Ack has priority over the terminal count in the same cycle.
    assign timeout   = (state_q == ST_MEM) && !dmem_ack && timer_tc;

    mem_ack_timer #(
        .LIMIT (ACK_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (enter_mem),
        .enable (state_q == ST_MEM),
        .tc     (timer_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_WB: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (is_mem_op)         state_d = ST_MEM;
                    else if (ex_reg_write) state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack)      state_d = dmem_we ? ST_IDLE : ST_WB;
                else if (timer_tc) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so the write port and memory
    // bus read as zero after reset rather than stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_we    <= 1'b0;
            dest_q     <= '0;
            wb_data_q  <= '0;
            mem_err    <= 1'b0;
        end else begin
            if (enter_mem) begin
                dmem_addr  <= ex_result;
                dmem_wdata <= ex_store_data;
                dmem_we    <= (ex_opcode == OP_SW);
                dest_q     <= ex_dest;
            end else if (accept && ex_reg_write) begin
                wb_data_q <= ex_result;
                dest_q    <= ex_dest;
            end
            if (load_done) wb_data_q <= dmem_rdata;
            if (timeout)   mem_err   <= 1'b1;
        end
    end

    assign dmem_req       = (state_q == ST_MEM);
    assign stall          = (state_q == ST_MEM);
    // $0 is hard-wired to zero, so writes to it are suppressed.
    assign write          = (state_q == ST_WB) && (dest_q != 5'd0);
    assign write_address  = dest_q;
    assign write_material = wb_data_q;

`ifdef MEM_WB_FWD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= write;
            fwd_addr  <= write_address;
            fwd_data  <= write_material;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (ALU, LW, SW, $0, timeout,
// ack-at-limit, async reset mid-MEM). Honours MEM_WB_FWD_EN when defined.
module tb_mem_wb_stage;
    import mem_wb_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid, ex_ready, ex_reg_write;
    logic [5:0]    ex_opcode;
    logic [DW-1:0] ex_result, ex_store_data;
    logic [4:0]    ex_dest;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          write, stall, mem_err;
    logic [4:0]    write_address;
    logic [DW-1:0] write_material;
`ifdef MEM_WB_FWD_EN
    logic          fwd_valid;
    logic [4:0]    fwd_addr;
    logic [DW-1:0] fwd_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_wb_stage #(.DATA_W(DW), .ACK_TIMEOUT(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_opcode      (ex_opcode),
        .ex_result      (ex_result),
        .ex_store_data  (ex_store_data),
        .ex_dest        (ex_dest),
        .ex_reg_write   (ex_reg_write),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .write          (write),
        .write_address  (write_address),
        .write_material (write_material),
        .stall          (stall),
        .mem_err        (mem_err)
`ifdef MEM_WB_FWD_EN
        ,
        .fwd_valid      (fwd_valid),
        .fwd_addr       (fwd_addr),
        .fwd_data       (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [5:0] op, input logic [31:0] res, input logic [31:0] sd,
                           input logic [4:0] dst, input logic rw);
        ex_valid      = 1'b1;
        ex_opcode     = op;
        ex_result     = res;
        ex_store_data = sd;
        ex_dest       = dst;
        ex_reg_write  = rw;
    endtask

    task automatic idle_ex();
        ex_valid     = 1'b0;
        ex_reg_write = 1'b0;
    endtask

    int stall_cycles;

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_opcode = '0; ex_result = '0; ex_store_data = '0;
        ex_dest = '0; ex_reg_write = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        #12;
        check("rst_ex_ready", ex_ready, 1);
        check("rst_write", write, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_write_addr", write_address, 0);
`ifdef MEM_WB_FWD_EN
        check("rst_fwd_valid", fwd_valid, 0);
`endif
        rst_n = 1'b1;
        step();

        // ALU op, then a second one back-to-back accepted from WB.
        present(6'b000000, 32'h0000_0042, 32'h0, 5'd5, 1'b1);
        step();
        check("alu_write", write, 1);
        check("alu_addr", write_address, 5);
        check("alu_data", write_material, 32'h42);
        check("alu_ready", ex_ready, 1);
        present(6'b001000, 32'h0000_0077, 32'h0, 5'd6, 1'b1);
        step();
        check("b2b_write", write, 1);
        check("b2b_addr", write_address, 6);
        check("b2b_data", write_material, 32'h77);
`ifdef MEM_WB_FWD_EN
        check("fwd_valid", fwd_valid, 1);
        check("fwd_addr", fwd_addr, 5);
        check("fwd_data", fwd_data, 32'h42);
`endif
        idle_ex();
        step();
        check("b2b_write_drop", write, 0);

        // Destination $0 and reg_write=0 retire without a write.
        present(6'b000000, 32'h0000_0099, 32'h0, 5'd0, 1'b1);
        step();
        check("dest0_write", write, 0);
        present(6'b000000, 32'h0000_0033, 32'h0, 5'd7, 1'b0);
        step();
        check("norw_write", write, 0);
        check("norw_stall", stall, 0);
        idle_ex();

        // Ack outside MEM is ignored.
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        step();
        dmem_ack = 1'b0;
        check("stray_ack_write", write, 0);
        check("stray_ack_stall", stall, 0);

        // LW addr 0x100, ack in the 3rd MEM cycle; an offer during MEM is refused.
        present(OP_LW, 32'h0000_0100, 32'h0, 5'd8, 1'b1);
        step();
        present(6'b000000, 32'h0000_0055, 32'h0, 5'd9, 1'b1);
        check("lw_req", dmem_req, 1);
        check("lw_we", dmem_we, 0);
        check("lw_addr", dmem_addr, 32'h100);
        check("lw_ready", ex_ready, 0);
        stall_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (stall) stall_cycles++;
            if (i == 1) idle_ex();
            if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
            step();
        end
        dmem_ack = 1'b0;
        check("lw_stall_cycles", stall_cycles, 3);
        check("lw_write", write, 1);
        check("lw_waddr", write_address, 8);
        check("lw_wdata", write_material, 32'hDEAD_BEEF);
        check("lw_stall_fall", stall, 0);
        step();
        check("lw_write_once", write, 0);

        // SW addr 0x200 data 0x1234; EX inputs change but the bus must hold.
        present(OP_SW, 32'h0000_0200, 32'h0000_1234, 5'd0, 1'b0);
        step();
        idle_ex(); ex_result = 32'hFFFF_FFFF; ex_store_data = 32'hAAAA_AAAA;
        for (int i = 0; i < 2; i++) begin
            check("sw_req", dmem_req, 1);
            check("sw_we", dmem_we, 1);
            check("sw_addr", dmem_addr, 32'h200);
            check("sw_wdata", dmem_wdata, 32'h1234);
            step();
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("sw_req_fall", dmem_req, 0);
        check("sw_no_write", write, 0);
        check("sw_stall_fall", stall, 0);

        // No ack: abort after 16 MEM cycles, mem_err sticky.
        present(OP_LW, 32'h0000_0300, 32'h0, 5'd10, 1'b1);
        step();
        idle_ex();
        stall_cycles = 0;
        while (stall && stall_cycles < 40) begin
            stall_cycles++;
            step();
        end
        check("to_stall_cycles", stall_cycles, 16);
        check("to_mem_err", mem_err, 1);
        check("to_req", dmem_req, 0);
        check("to_no_write", write, 0);
        check("to_ready", ex_ready, 1);
        present(6'b000000, 32'h0000_0ABC, 32'h0, 5'd11, 1'b1);
        step();
        idle_ex();
        check("post_to_write", write, 1);
        check("post_to_data", write_material, 32'hABC);

        // Ack on the 16th MEM cycle wins over the timeout.
        present(OP_LW, 32'h0000_0400, 32'h0, 5'd12, 1'b1);
        step();
        idle_ex();
        for (int i = 0; i < 15; i++) step();
        check("lim_still_mem", stall, 1);
        dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
        step();
        dmem_ack = 1'b0;
        check("lim_write", write, 1);
        check("lim_waddr", write_address, 12);
        check("lim_wdata", write_material, 32'h1357_9BDF);
        step();

        // Async reset in MEM drops req/stall immediately; no write afterwards.
        present(OP_LW, 32'h0000_0500, 32'h0, 5'd13, 1'b1);
        step();
        idle_ex();
        check("rstmem_req_before", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmem_req", dmem_req, 0);
        check("rstmem_stall", stall, 0);
        check("rstmem_write", write, 0);
        check("rstmem_mem_err", mem_err, 0);
        #3 rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h2468_ACE0;
        step();
        dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstmem_no_write", write, 0);
            step();
        end
        check("rstmem_ready", ex_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage of the MIPS-32 pipeline. Accepts executed instructions from the EX stage (ALU result, store data, destination), performs load/store transactions to data memory over a req/ack handshake, and drives the register file write port (`write`, `write_address`, `write_material`). While a memory transaction is outstanding, it raises `stall` to hold the front end.

## Interface
Parameters:
- `DATA_W`, 32, datapath and memory word width
- `ACK_TIMEOUT`, 16, maximum cycles in MEM waiting for `dmem_ack` before abort

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  EX stage presents an instruction
- `ex_ready`  out  1  stage accepts on this edge when `ex_valid & ex_ready`
- `ex_opcode`  in  6  instruction opcode
- `ex_result`  in  DATA_W  ALU output; register data or memory address
- `ex_store_data`  in  DATA_W  Rt value for stores
- `ex_dest`  in  5  destination register
- `ex_reg_write`  in  1  instruction writes a register
- `dmem_req`  out  1  memory request
- `dmem_we`  out  1  1 = store, 0 = load
- `dmem_addr`  out  DATA_W  memory address
- `dmem_wdata`  out  DATA_W  store data
- `dmem_ack`  in  1  memory completes the request; `dmem_rdata` is valid in the same cycle
- `dmem_rdata`  in  DATA_W  load data
- `write`  out  1  register file write enable
- `write_address`  out  5  register file write address
- `write_material`  out  DATA_W  register file write data
- `stall`  out  1  high while state is MEM
- `mem_err`  out  1  sticky; set on ack timeout

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, MEM, WB. Reset enters IDLE. All registered outputs reset to 0. `mem_err` resets to 0.
- `ex_ready` = (state is IDLE or WB). It is combinational from state, so it reads 1 immediately after reset.
- Accepting in IDLE or WB:
  - opcode `OP_LW` or `OP_SW` → MEM. Latch `dmem_addr`=`ex_result`, `dmem_wdata`=`ex_store_data`, `dmem_we`=(opcode==`OP_SW`), and the destination.
  - other opcode with `ex_reg_write`=1 → WB. Latch `ex_result` and `ex_dest`.
  - other opcode with `ex_reg_write`=0 → IDLE (retired, no effect).
- No accept while in WB → IDLE.
- MEM:
  - `dmem_req`=1. Address, data and we are held stable until ack.
  - On `dmem_ack`: a load latches `dmem_rdata` and goes to WB. A store goes to IDLE.
- WB: `write`=1 for exactly one cycle. If the latched destination is 0, `write` stays 0 because $0 is immutable.
- Ack timer: counts cycles in MEM and clears on entry.
  - If the count reaches `ACK_TIMEOUT` without ack: set `mem_err`, drop `dmem_req`, return to IDLE, no write-back.
  - Ack in the same cycle the count reaches the limit: ack wins.
- `dmem_ack` outside MEM is ignored.
- `ex_valid` while `ex_ready`=0: not accepted; EX must hold its inputs.

## Timing
- ALU op accepted at edge N → `write`=1 during cycle N+1.
- Load accepted at edge N → `dmem_req`=1 from cycle N+1. Ack sampled at edge M → `write`=1 during cycle M+1.
- Store: `dmem_req` falls in the cycle after the ack edge.
- Back-to-back ALU ops sustain one per cycle, because WB accepts.
- `stall` rises in the cycle after a load/store accept and falls in the cycle after the ack edge.
- Reset mid-MEM: `dmem_req`, `write` and `stall` drop asynchronously. The transaction is abandoned with no write-back.

## Configuration
- `MEM_WB_FWD_EN` defined:
  - adds outputs `fwd_valid` (1), `fwd_addr` (5) and `fwd_data` (DATA_W);
  - these are a registered copy of the previous cycle's write port, covering the register file write-then-read hazard for one extra cycle;
  - all three reset to 0.
- Undefined: these ports and registers do not exist.

## Structure
- Package `mem_wb_pkg` holds `OP_LW`=6'b100011, `OP_SW`=6'b101011, the state enum, and the default `DATA_W`.
- Sub-module `mem_ack_timer` is the MEM-state cycle counter with a terminal-count output.

## Test plan
- ALU op: `ex_result`=0x0000_0042, dest=5, reg_write=1 → `write`=1, `write_address`=5, `write_material`=0x42 the next cycle. `ex_ready` stays 1.
- LW: addr 0x100, memory acks after 3 cycles with 0xDEAD_BEEF, dest=8 → `stall` high for 3 cycles, then write to reg 8 with 0xDEADBEEF.
- SW: addr 0x200, data 0x1234 → `dmem_req`=1 with `dmem_we`=1, addr 0x200, wdata 0x1234 held stable until ack. No `write`.
- Dest 0 with reg_write=1 → `write` stays 0.
- No ack for 16 cycles in MEM → `mem_err`=1, `dmem_req`=0, state IDLE. A later ALU op still writes back.
- `rst_n` low during MEM → `dmem_req`=`stall`=0 immediately. No write after release.
